game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Top-level match sequencer for the pong game.
- Tracks scores and steps through idle, serve, play, pause, point and win phases.
- Drives the screen renderer's render enable (the renderer's active-low reset) and its 2-bit winner code.
- Holds and recentres the ball engine between rallies; the ball/collision logic supplies per-side miss pulses.

Parameters:
- WIN_SCORE, 5, points needed to win; legal 1..15.
- SERVE_FRAMES, 60, frame ticks the ball is held before release; legal ≥1.
- POINT_FRAMES, 90, frame ticks of hold after a point before the next serve; legal ≥1.
- CNT_W, 8, width of the frame-tick phase counter; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- frame_tick  in  1  one-clk pulse per video frame.
- start  in  1  raw start button, level, asynchronous.
- pause  in  1  level, synchronous to clk; freezes play while high.
- miss_left  in  1  one-clk pulse: ball passed the left edge, point to player 2.
- miss_right  in  1  one-clk pulse: ball passed the right edge, point to player 1.
- render_en  out  1  to renderer reset; 0 blanks the screen.
- winner  out  2  renderer code: 00 idle, 01 game active, 10 P1 won, 11 P2 won.
- ball_hold  out  1  1 freezes ball motion.
- ball_recentre  out  1  one-clk pulse; ball engine reloads centre position.
- score1  out  4  player 1 (left paddle) score.
- score2  out  4  player 2 (right paddle) score.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, scores=0, counter=0, start sync flops=0.
  - Outputs: render_en=0, winner=00, ball_hold=1, ball_recentre=0.
- Start input:
  - Two-flop synchroniser, then rising-edge detect gives start_pulse.
  - First state change occurs on the 3rd clk edge after start goes high.
  - A held button produces only one pulse.
- Moore outputs decoded from the state register, same cycle as the state:
  - IDLE: render_en 0, winner 00, hold 1.
  - SERVE, PAUSE, POINT: render_en 1, winner 01, hold 1.
  - PLAY: render_en 1, winner 01, hold 0.
  - WIN1: render_en 1, winner 10, hold 1.
  - WIN2: render_en 1, winner 11, hold 1.
- ball_recentre is registered: high for exactly the first cycle in SERVE on every SERVE entry.
- Transitions:
  - IDLE → SERVE on start_pulse; scores cleared.
  - SERVE: counter cleared on entry, increments per frame_tick. On the frame_tick with counter==SERVE_FRAMES-1 → PLAY, so exactly SERVE_FRAMES ticks.
  - PLAY, miss_right alone: score1 += 1 at that edge. If the new score1==WIN_SCORE → WIN1, else → POINT.
  - PLAY, miss_left alone: same rule for score2, going to WIN2 or POINT.
  - PLAY, miss_left and miss_right in the same cycle: both ignored, stay in PLAY.
  - PLAY, pause=1 with no miss → PAUSE. A miss has priority over pause in the same cycle.
  - PAUSE → PLAY when pause=0. Misses and frame_ticks in PAUSE are ignored.
  - POINT: counter cleared on entry; after POINT_FRAMES ticks → SERVE.
  - WIN1/WIN2: hold until start_pulse → SERVE, with both scores cleared at that edge.
- Ignored inputs:
  - Misses outside PLAY are ignored.
  - start_pulse in SERVE, PLAY, PAUSE or POINT is ignored.
  - frame_tick only advances the counter in SERVE and POINT.
- Scores never exceed WIN_SCORE and never wrap; a win is reached exactly on the increment to WIN_SCORE.
- Reset asserted mid-game forces IDLE immediately and asynchronously, with all values at reset state; no partial score survives.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package game_pkg holds:
  - state enum: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, WIN1=5, WIN2=6;
  - winner code constants: WIN_NONE=00, WIN_ACTIVE=01, WIN_P1=10, WIN_P2=11.
  - The renderer and the 7-segment score display reuse these.
- One sub-module, button_edge_sync: two-flop synchroniser plus rising-edge pulse. It is reused for the pad buttons.

Test Plan:
- Boot and start:
  - Release reset, raise start at cycle 10 → state SERVE at the 3rd edge, winner 01, render_en 1, ball_recentre one cycle.
  - Start held 1000 cycles → no second pulse.
- Serve timing:
  - SERVE_FRAMES=3, ticks every 8 clks → PLAY after the 3rd tick, ball_hold falls that cycle.
- Scoring: in PLAY, pulse miss_right → score1=1, POINT. POINT_FRAMES=2 → SERVE after 2 ticks with ball_recentre pulse.
- Win:
  - WIN_SCORE=3, score2=2, pulse miss_left → score2=3, WIN2, winner 11, ball_hold 1.
  - start pulse → SERVE, scores 0/0.
- Corner cases:
  - miss_left and miss_right same cycle → scores unchanged, stay PLAY.
  - pause=1 and miss_right same cycle → POINT, score1+1.
  - Misses during PAUSE → ignored.
- Reset mid-game: score1=2, score2=1, PLAY, assert reset between edges → outputs drop to IDLE values immediately, scores 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared match-flow types: state encoding and the renderer's winner codes.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    WIN1  = 3'd5,
    WIN2  = 3'd6
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_ACTIVE = 2'b01;
  localparam logic [1:0] WIN_P1     = 2'b10;
  localparam logic [1:0] WIN_P2     = 2'b11;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser for an asynchronous button plus a one-clock rising-edge pulse.
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  // Combinational edge so the state reacts on the third edge after the press
  assign pulse = sync2 & ~sync2_q;

endmodule

// File: rtl/game_flow_controller.sv
// Pong match sequencer: scores, serve/point hold timing, pause, win detection.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       render_en,
  output logic [1:0] winner,
  output logic       ball_hold,
  output logic       ball_recentre,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

  state_t           state, state_nxt;
  logic [3:0]       score1_nxt, score2_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_pulse;

  button_edge_sync u_start_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (start),
    .pulse (start_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      score1        <= '0;
      score2        <= '0;
      cnt           <= '0;
      ball_recentre <= 1'b0;
    end else begin
      state         <= state_nxt;
      score1        <= score1_nxt;
      score2        <= score2_nxt;
      cnt           <= cnt_nxt;
      ball_recentre <= (state_nxt == SERVE) && (state != SERVE);
    end
  end

  always_comb begin
    state_nxt  = state;
    score1_nxt = score1;
    score2_nxt = score2;
    cnt_nxt    = cnt;
    case (state)
      IDLE, WIN1, WIN2: begin
        if (start_pulse) begin
          state_nxt  = SERVE;
          score1_nxt = '0;
          score2_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == SERVE_LAST) state_nxt = PLAY;
          else                   cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      PLAY: begin
        // Simultaneous misses cancel out and also mask pause for that cycle
        if (miss_right && !miss_left) begin
          score1_nxt = score1 + 4'd1;
          state_nxt  = (score1_nxt == WIN_VAL) ? WIN1 : POINT;
          cnt_nxt    = '0;
        end else if (miss_left && !miss_right) begin
          score2_nxt = score2 + 4'd1;
          state_nxt  = (score2_nxt == WIN_VAL) ? WIN2 : POINT;
          cnt_nxt    = '0;
        end else if (pause && !miss_left && !miss_right) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (!pause) state_nxt = PLAY;
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt == POINT_LAST) begin
            state_nxt = SERVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    render_en = 1'b1;
    winner    = WIN_ACTIVE;
    ball_hold = 1'b1;
    case (state)
      IDLE: begin
        render_en = 1'b0;
        winner    = WIN_NONE;
      end
      PLAY:    ball_hold = 1'b0;
      WIN1:    winner    = WIN_P1;
      WIN2:    winner    = WIN_P2;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Randomised bench for game_flow_controller against a behavioural match model.
module tb_game_flow_controller;

  localparam int unsigned WIN_SCORE    = 3;
  localparam int unsigned SERVE_FRAMES = 3;
  localparam int unsigned POINT_FRAMES = 2;

  // Phase numbers as they appear on state_dbg
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_PAUSE = 3,
                 P_POINT = 4, P_WIN1 = 5, P_WIN2 = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic       miss_left = 1'b0, miss_right = 1'b0;
  logic       render_en, ball_hold, ball_recentre;
  logic [1:0] winner;
  logic [3:0] score1, score2;
  logic [2:0] state_dbg;

  game_flow_controller #(
    .WIN_SCORE    (WIN_SCORE),
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .CNT_W        (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .pause         (pause),
    .miss_left     (miss_left),
    .miss_right    (miss_right),
    .render_en     (render_en),
    .winner        (winner),
    .ball_hold     (ball_hold),
    .ball_recentre (ball_recentre),
    .score1        (score1),
    .score2        (score2),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  int m_phase, m_s1, m_s2, m_ticks;
  bit m_recentre;
  bit m_hist[3];   // start as seen at the previous three edges, newest first
  int cyc = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_s1       = 0;
    m_s2       = 0;
    m_ticks    = 0;
    m_recentre = 0;
    m_hist     = '{0, 0, 0};
  endtask

  task automatic enter_serve();
    m_phase    = P_SERVE;
    m_ticks    = 0;
    m_recentre = 1;
  endtask

  task automatic model_step();
    bit press;
    press      = m_hist[1] && !m_hist[2];
    m_hist[2]  = m_hist[1];
    m_hist[1]  = m_hist[0];
    m_hist[0]  = start;
    m_recentre = 0;
    case (m_phase)
      P_IDLE, P_WIN1, P_WIN2:
        if (press) begin
          m_s1 = 0;
          m_s2 = 0;
          enter_serve();
        end
      P_SERVE:
        if (frame_tick) begin
          m_ticks++;
          if (m_ticks == SERVE_FRAMES) m_phase = P_PLAY;
        end
      P_PLAY:
        if (miss_right && !miss_left) begin
          m_s1++;
          m_phase = (m_s1 == WIN_SCORE) ? P_WIN1 : P_POINT;
          m_ticks = 0;
        end else if (miss_left && !miss_right) begin
          m_s2++;
          m_phase = (m_s2 == WIN_SCORE) ? P_WIN2 : P_POINT;
          m_ticks = 0;
        end else if (pause && !(miss_left && miss_right)) begin
          m_phase = P_PAUSE;
        end
      P_PAUSE:
        if (!pause) m_phase = P_PLAY;
      P_POINT:
        if (frame_tick) begin
          m_ticks++;
          if (m_ticks == POINT_FRAMES) enter_serve();
        end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    int exp_win;
    exp_win = (m_phase == P_IDLE) ? 0 : (m_phase == P_WIN1) ? 2 :
              (m_phase == P_WIN2) ? 3 : 1;
    check_eq("state_dbg",     state_dbg,     m_phase);
    check_eq("render_en",     render_en,     m_phase != P_IDLE);
    check_eq("winner",        winner,        exp_win);
    check_eq("ball_hold",     ball_hold,     m_phase != P_PLAY);
    check_eq("ball_recentre", ball_recentre, m_recentre);
    check_eq("score1",        score1,        m_s1);
    check_eq("score2",        score2,        m_s2);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic drive_random(input bit tick_every8, input bit toggle_start);
    frame_tick = tick_every8 ? (cyc % 8 == 0) : ($urandom_range(0, 5) == 0);
    miss_left  = ($urandom_range(0, 9) == 0);
    miss_right = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 29) == 0) pause = ~pause;
    if (toggle_start && $urandom_range(0, 39) == 0) start = ~start;
  endtask

  // Asynchronous reset between edges; outputs must fall to idle values at once
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    reset = 1'b1;
    repeat (9) cycle();
    // Held start: exactly one press, so a finished match stays in its win phase
    start = 1'b1;
    repeat (1000) begin
      drive_random(1'b1, 1'b0);
      cycle();
    end
    start = 1'b0;
    for (int unsigned blk = 0; blk < 12; blk++) begin
      repeat (1500) begin
        drive_random(1'b0, 1'b1);
        cycle();
      end
      // Prefer hitting reset while a rally is live with points on the board
      for (int unsigned w = 0; w < 400; w++) begin
        if (m_phase == P_PLAY && (m_s1 + m_s2) > 0) break;
        drive_random(1'b0, 1'b1);
        cycle();
      end
      mid_reset();
    end
    repeat (20) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
